// File: rtl/segment_scan_controller_if.sv
// Host-side bus of the seven-segment scan controller.
//   value      : 16-bit display value, digit3 = [15:12] ... digit0 = [3:0]
//   dp_mask    : decimal point enable per digit
//   blank_mask : force-dark per digit
//   lz_en      : leading-zero suppression enable
//   load       : one-cycle strobe capturing the four fields above
//   pending    : a loaded value is waiting for the next frame boundary
//   frame_done : one-cycle pulse on each commit into the active register
interface segment_scan_controller_if;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic        load;
    logic        pending;
    logic        frame_done;

    modport master (
        output value, dp_mask, blank_mask, lz_en, load,
        input  pending, frame_done
    );

    modport slave (
        input  value, dp_mask, blank_mask, lz_en, load,
        output pending, frame_done
    );
endinterface

// File: rtl/segment_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Shares one BCD decoder (inputs A..D, A = MSB; codes 10-15 decode blank)
// across active-low anodes AN0..AN3. Display settings are double-buffered
// and committed only at frame boundaries; each digit slot starts with an
// all-anodes-off interval to prevent ghosting.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   bus            : host bus (value/masks/lz_en/load in, pending/frame_done out)
//   A, B, C, D     : digit code to the decoder
//   dp             : active-low decimal point
//   AN0..AN3       : active-low digit anodes
module segment_scan_controller #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    segment_scan_controller_if.slave bus,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic dp,
    output logic AN0,
    output logic AN1,
    output logic AN2,
    output logic AN3
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     idx_q;

    logic [15:0]    act_value, sh_value;
    logic [3:0]     act_dp, sh_dp;
    logic [3:0]     act_blank, sh_blank;
    logic           act_lz, sh_lz;
    logic           pending_q, frame_done_q;

    logic [3:0]     code_q, code_d;
    logic [3:0]     an_q, an_d;
    logic           dp_q, dp_d;

    logic           slot_wrap, frame_wrap;
    logic [3:0]     digit;
    logic [3:0]     lz_sup;
    logic           suppressed;

    assign slot_wrap  = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_wrap && (idx_q == 2'd3);

    always_comb begin
        digit = '0;
        case (idx_q)
            2'd0: digit = act_value[3:0];
            2'd1: digit = act_value[7:4];
            2'd2: digit = act_value[11:8];
            2'd3: digit = act_value[15:12];
            default: digit = '0;
        endcase
    end

    // A digit is a leading zero when it and every digit above it are zero;
    // digit0 always shows so a zero value still displays "0".
    always_comb begin
        lz_sup    = '0;
        lz_sup[3] = act_lz && (act_value[15:12] == 4'd0);
        lz_sup[2] = lz_sup[3] && (act_value[11:8] == 4'd0);
        lz_sup[1] = lz_sup[2] && (act_value[7:4] == 4'd0);
        lz_sup[0] = 1'b0;
    end

    assign suppressed = act_blank[idx_q] | lz_sup[idx_q];

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_BLANK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        code_d  = suppressed ? 4'hF : digit;
        an_d    = '1;
        dp_d    = 1'b1;
        if (slot_wrap)
            state_d = ST_BLANK;
        else if (cnt_q == BLANK_LAST)
            state_d = ST_DRIVE;
        if (state_q == ST_DRIVE && !suppressed) begin
            an_d[idx_q] = 1'b0;
            dp_d        = ~act_dp[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_value    <= '0;
            act_dp       <= '0;
            act_blank    <= '1;
            act_lz       <= 1'b0;
            sh_value     <= '0;
            sh_dp        <= '0;
            sh_blank     <= '0;
            sh_lz        <= 1'b0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            code_q       <= '1;
            an_q         <= '1;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= slot_wrap ? '0 : cnt_q + 1'b1;
            if (slot_wrap)
                idx_q <= idx_q + 2'd1;
            code_q       <= code_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_done_q <= 1'b0;
            if (frame_wrap) begin
                // A load on the wrap cycle bypasses the shadow entirely.
                if (bus.load) begin
                    act_value    <= bus.value;
                    act_dp       <= bus.dp_mask;
                    act_blank    <= bus.blank_mask;
                    act_lz       <= bus.lz_en;
                    pending_q    <= 1'b0;
                    frame_done_q <= 1'b1;
                end else if (pending_q) begin
                    act_value    <= sh_value;
                    act_dp       <= sh_dp;
                    act_blank    <= sh_blank;
                    act_lz       <= sh_lz;
                    pending_q    <= 1'b0;
                    frame_done_q <= 1'b1;
                end
            end else if (bus.load) begin
                sh_value  <= bus.value;
                sh_dp     <= bus.dp_mask;
                sh_blank  <= bus.blank_mask;
                sh_lz     <= bus.lz_en;
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;
    assign {A, B, C, D}   = code_q;
    assign dp             = dp_q;
    assign AN0            = an_q[0];
    assign AN1            = an_q[1];
    assign AN2            = an_q[2];
    assign AN3            = an_q[3];
endmodule

// File: doc/segment_scan_controller.md
# segment_scan_controller

Time-multiplexed scan controller for the 4-digit seven-segment display. It owns the single BCD-to-segment decoder, whose inputs are A (MSB) to D (LSB) and whose active-low segment outputs go blank for codes 10–15. The controller time-shares that decoder across the four active-low anodes AN0–AN3. It also:
- double-buffers a 16-bit display value, committing it only at frame boundaries so digits never tear;
- inserts an anti-ghosting blank interval before each digit;
- applies per-digit blanking, decimal-point control and optional leading-zero suppression.

## Interface

Parameters:
- SLOT_CYCLES, default 100000. Clock cycles per digit slot. Must be ≥ 4.
- BLANK_CYCLES, default 1000. Cycles at the start of each slot with all anodes off. Valid range is 1 ≤ BLANK_CYCLES < SLOT_CYCLES.

Ports:
- clk, in, 1. Single clock. Every register is clocked on the rising edge.
- reset, in, 1. Synchronous, active-high.
- value, in, 16. Display value. Digit3 = [15:12], digit2 = [11:8], digit1 = [7:4], digit0 = [3:0].
- dp_mask, in, 4. Bit i = 1 lights the decimal point of digit i.
- blank_mask, in, 4. Bit i = 1 forces digit i dark.
- lz_en, in, 1. Enables leading-zero suppression.
- load, in, 1. One-cycle strobe. Captures value, dp_mask, blank_mask and lz_en into the shadow register.
- pending, out, 1. High while a shadow value awaits commit.
- frame_done, out, 1. One-cycle pulse on each commit.
- A, B, C, D, out, 1 each. Digit code to the decoder; A is the MSB.
- dp, out, 1. Active-low decimal point.
- AN0, AN1, AN2, AN3, out, 1 each. Active-low digit anodes.

## Operation

State and counters:
- `cnt` counts 0 to SLOT_CYCLES−1 and wraps. `idx` (2 bits) increments when `cnt` wraps; idx 3 wraps to 0.
- The FSM has two states:
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE while cnt ≥ BLANK_CYCLES.
  - Transitions: BLANK→DRIVE at cnt = BLANK_CYCLES; DRIVE→BLANK at the slot wrap.

Frame wrap (the cycle idx goes 3→0):
- If pending = 1, the shadow copies into the active register, pending clears and frame_done pulses.
- If load is high on the wrap cycle, the live inputs commit directly, pending stays 0 and frame_done pulses.

Load outside the wrap cycle:
- The shadow is overwritten and pending is set.
- Repeated loads before a wrap keep only the last one, and produce a single frame_done.

Suppression of digit idx (active register only):
- A digit is suppressed if blank_mask[idx] = 1.
- With lz_en = 1, a digit is also suppressed if it and every more-significant digit are zero. Digit0 is never lz-suppressed.
- For a suppressed digit, code = 4'hF (decoder blank) and its anode stays high for the whole slot. dp follows dp_mask regardless of suppression, but only while the anode is low, so in practice it stays off.

Normal digit:
- BLANK state: {A,B,C,D} = the digit's code, all anodes high, dp = 1.
- DRIVE state: the code is held, AN[idx] = 0, and dp = ~dp_mask[idx].

Reset:
- idx = 0, cnt = 0, state BLANK.
- Active register: value 0, blank_mask 4'b1111, dp_mask 0, lz_en 0. The display stays dark until the first commit.
- Shadow register cleared, pending = 0.

## Timing

- All outputs are registered. Each output reflects the cnt/idx/state of the previous cycle, so latency is 1 cycle.
- Reset value of every output, valid the cycle after reset is sampled high:
  - AN0–AN3 = 1111
  - {A,B,C,D} = 1111
  - dp = 1
  - pending = 0
  - frame_done = 0
- Reset asserted mid-slot or mid-frame aborts immediately. Any pending load is discarded and the scan restarts at digit0, BLANK.
- Anode timing per slot: each anode is low for exactly SLOT_CYCLES − BLANK_CYCLES consecutive cycles. At most one anode is ever low. Every anode edge is separated by ≥ BLANK_CYCLES all-high cycles.
- The code changes only in the first cycle of BLANK, never while an anode is low.
- pending:
  - rises the cycle after a non-wrap load;
  - falls the cycle after the wrap, coincident with frame_done high.
- Frame period = 4 × SLOT_CYCLES.

## Test plan

All scenarios use SLOT_CYCLES = 8, BLANK_CYCLES = 2.

- **Reset:** hold reset 3 cycles, then run 40 cycles with no load → AN = 1111, ABCD = 1111, dp = 1, pending = 0 throughout.
- **Normal load:** load value = 16'h1234, masks 0, lz_en = 0 →
  - pending = 1 until the wrap, then one frame_done pulse;
  - in each following slot: 2 all-high cycles, then 6 cycles of AN[i] = 0;
  - codes: digit0 = 0100, digit1 = 0011, digit2 = 0010, digit3 = 0001.
- **Leading zeros:**
  - value = 16'h0045, lz_en = 1 → AN3 and AN2 never low; AN1 shows 0100; AN0 shows 0101.
  - value = 16'h0000 → only AN0 asserts, with code 0000.
  - value = 16'h0405 → AN3 stays high; AN2 shows 0100, AN1 shows 0000, AN0 shows 0101.
- **Double load:** load 16'h1111, then 16'h2222 three cycles later, both before the wrap → one frame_done; all four digits show 0010.
- **Load on wrap cycle:** load coincident with idx 3→0 → pending never rises; frame_done pulses; the new code is shown in the digit0 slot.
- **Decimal point and mid-slot reset:**
  - dp_mask = 4'b0010 → dp = 0 only during AN1-low cycles.
  - Asserting reset during the digit2 DRIVE state → next cycle outputs are at reset values, and the scan restarts at digit0 dark.
